// File: rtl/if_spike_aer_tx.sv
// Serialises the IF layer's parallel spike vector into an AER address stream with a per-neuron refractory window.
// Optional AER_TIMESTAMP_EN adds a free-running cycle stamp carried with each event on aer_ts.
module if_spike_aer_tx #(
   parameter int NUM_OUTPUTS = 4,
   parameter int ADDR_W      = 2,
   parameter int REFRAC      = 5
`ifdef AER_TIMESTAMP_EN
   ,
   parameter int TS_W        = 16
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_OUTPUTS-1:0] spike_in,
   output logic [ADDR_W-1:0]      aer_addr,
   output logic                   aer_valid,
   input  logic                   aer_ready,
   output logic                   overflow,
   output logic                   busy
`ifdef AER_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]        aer_ts
`endif
);

   localparam int CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic [CNT_W-1:0] REFRAC_V = CNT_W'(REFRAC);

   typedef enum logic {IDLE, SEND} state_e;

   state_e                 state_q, state_d;
   logic [NUM_OUTPUTS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]       cnt_q [NUM_OUTPUTS];
   logic [CNT_W-1:0]       cnt_d [NUM_OUTPUTS];
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   valid_q, valid_d;
   logic                   overflow_q, overflow_d;

   logic [NUM_OUTPUTS-1:0] accept, clr, drop, remain;
   logic                   handshake;
   logic                   load_event;

   function automatic logic [ADDR_W-1:0] lowest(input logic [NUM_OUTPUTS-1:0] v);
      lowest = '0;
      for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
         if (v[i]) lowest = ADDR_W'(i);
      end
   endfunction

   // Refractory counters and pending set/clear; an accepted spike wins over a same-edge clear.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      accept    = '0;
      clr       = '0;
      cnt_d     = cnt_q;
      handshake = valid_q && aer_ready;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         accept[i] = spike_in[i] && (cnt_q[i] == '0);
         clr[i]    = handshake && (addr_q == ADDR_W'(i));
         if (accept[i])             cnt_d[i] = REFRAC_V;
         else if (cnt_q[i] != '0)   cnt_d[i] = cnt_q[i] - 1'b1;
      end
      drop       = accept & pending_q & ~clr;
      remain     = pending_q & ~clr;
      pending_d  = remain | accept;
      overflow_d = overflow_q | (|drop);
   end

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      addr_d     = addr_q;
      load_event = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|pending_q) begin
               addr_d     = lowest(pending_q);
               valid_d    = 1'b1;
               load_event = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (handshake) begin
               if (|remain) begin
                  addr_d     = lowest(remain);
                  load_event = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign aer_addr  = addr_q;
   assign aer_valid = valid_q;
   assign overflow  = overflow_q;
   assign busy      = (|pending_q) | valid_q;

`ifdef AER_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] aer_ts_q;
   logic [TS_W-1:0] stamp_q [NUM_OUTPUTS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q     <= '0;
         aer_ts_q <= '0;
      end else begin
         ts_q <= ts_q + 1'b1;
         if (load_event) aer_ts_q <= stamp_q[addr_d];
      end
   end

   // NOTE: stamp storage has no reset; a slot is only read while its pending bit is set, which implies a write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (accept[i] && !drop[i]) stamp_q[i] <= ts_q;
      end
   end

   assign aer_ts = aer_ts_q;
`endif

endmodule

// File: tb/tb_if_spike_aer_tx.sv
// Directed bench for if_spike_aer_tx: expected addresses are queued at stimulus time and popped on each handshake.
module tb_if_spike_aer_tx;

   logic       clk;
   logic       rst;
   logic [3:0] spike_in;
   logic [1:0] aer_addr;
   logic       aer_valid;
   logic       aer_ready;
   logic       overflow;
   logic       busy;
`ifdef AER_TIMESTAMP_EN
   logic [15:0] aer_ts;
`endif

   int tests;
   int fails;
   logic [1:0] exp_q [$];

   if_spike_aer_tx #(.NUM_OUTPUTS(4), .ADDR_W(2), .REFRAC(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .spike_in  (spike_in),
      .aer_addr  (aer_addr),
      .aer_valid (aer_valid),
      .aer_ready (aer_ready),
      .overflow  (overflow),
      .busy      (busy)
`ifdef AER_TIMESTAMP_EN
      ,
      .aer_ts    (aer_ts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; registered outputs are settled by then.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (!rst && aer_valid && aer_ready) begin
         if (exp_q.size() == 0) check("unexpected_event", {30'd0, aer_addr}, 32'hFFFF_FFFF);
         else                   check("event_addr", {30'd0, aer_addr}, {30'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ev;
      int first;
      int second;
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      spike_in  = '0;
      aer_ready = 1'b0;
      repeat (3) cyc();
      check("reset_valid",    {31'd0, aer_valid}, 32'd0);
      check("reset_busy",     {31'd0, busy},      32'd0);
      check("reset_overflow", {31'd0, overflow},  32'd0);
      check("reset_addr",     {30'd0, aer_addr},  32'd0);
      rst = 1'b0;
      cyc();

      // Single spike on neuron 2, ready held high: valid two edges later for one cycle.
      aer_ready = 1'b1;
      spike_in  = 4'b0100;
      exp_q.push_back(2'd2);
      cyc();
      spike_in = '0;
      check("single_c1_valid", {31'd0, aer_valid}, 32'd0);
      check("single_c1_busy",  {31'd0, busy},      32'd1);
      cyc();
      check("single_c2_valid", {31'd0, aer_valid}, 32'd1);
      check("single_c2_addr",  {30'd0, aer_addr},  32'd2);
      cyc();
      check("single_c3_valid", {31'd0, aer_valid}, 32'd0);
      check("single_c3_busy",  {31'd0, busy},      32'd0);
      repeat (6) cyc();

      // Burst 1011: lowest index first, back-to-back.
      spike_in = 4'b1011;
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd3);
      cyc();
      spike_in = '0;
      cyc();
      check("burst_addr0", {30'd0, aer_addr}, 32'd0);
      cyc();
      check("burst_addr1", {30'd0, aer_addr}, 32'd1);
      check("burst_valid1", {31'd0, aer_valid}, 32'd1);
      cyc();
      check("burst_addr3", {30'd0, aer_addr}, 32'd3);
      check("burst_valid3", {31'd0, aer_valid}, 32'd1);
      cyc();
      check("burst_done_valid", {31'd0, aer_valid}, 32'd0);
      check("burst_done_busy",  {31'd0, busy},      32'd0);
      repeat (6) cyc();

      // Backpressure on neuron 0, then a re-spike after refractory while still pending.
      aer_ready = 1'b0;
      spike_in  = 4'b0001;
      exp_q.push_back(2'd0);
      cyc();
      spike_in = '0;
      cyc();
      check("bp_hold_valid", {31'd0, aer_valid}, 32'd1);
      check("bp_hold_addr",  {30'd0, aer_addr},  32'd0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("bp_hold_valid", {31'd0, aer_valid}, 32'd1);
         check("bp_hold_addr",  {30'd0, aer_addr},  32'd0);
      end
      check("bp_pre_overflow", {31'd0, overflow}, 32'd0);
      spike_in = 4'b0001;
      cyc();
      spike_in = '0;
      check("bp_overflow_set", {31'd0, overflow}, 32'd1);
      check("bp_still_addr",   {30'd0, aer_addr}, 32'd0);
      aer_ready = 1'b1;
      cyc();
      check("bp_done_valid",  {31'd0, aer_valid}, 32'd0);
      check("bp_done_busy",   {31'd0, busy},      32'd0);
      check("bp_overflow_sticky", {31'd0, overflow}, 32'd1);
      cyc();
      check("bp_overflow_sticky2", {31'd0, overflow}, 32'd1);

      // Asynchronous reset while an event is stalled in SEND.
      aer_ready = 1'b0;
      spike_in  = 4'b0100;
      cyc();
      spike_in = '0;
      cyc();
      check("rst_pre_valid", {31'd0, aer_valid}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst_async_valid",    {31'd0, aer_valid}, 32'd0);
      check("rst_async_overflow", {31'd0, overflow},  32'd0);
      check("rst_async_busy",     {31'd0, busy},      32'd0);
      cyc();
      rst       = 1'b0;
      aer_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check("rst_post_idle", {31'd0, aer_valid}, 32'd0);
      end

      // Neuron 1 held high for 12 sampled edges: two events 6 cycles apart.
      ev     = 0;
      first  = -1;
      second = -1;
      spike_in = 4'b0010;
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd1);
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k == 12) spike_in = '0;
         if (aer_valid) begin
            if (ev == 0) first = k;
            else         second = k;
            ev++;
         end
      end
      check("refrac_events",   ev,             32'd2);
      check("refrac_spacing",  second - first, 32'd6);
      check("refrac_overflow", {31'd0, overflow}, 32'd0);
      check("refrac_busy",     {31'd0, busy},     32'd0);

      // Re-spike on neuron 2 on the same edge as its handshake: set wins, no overflow.
      aer_ready = 1'b0;
      spike_in  = 4'b0100;
      exp_q.push_back(2'd2);
      cyc();
      spike_in = '0;
      cyc();
      check("setwin_addr", {30'd0, aer_addr}, 32'd2);
      repeat (4) cyc();
      spike_in  = 4'b0100;
      aer_ready = 1'b1;
      exp_q.push_back(2'd2);
      cyc();
      spike_in = '0;
      check("setwin_gap_valid", {31'd0, aer_valid}, 32'd0);
      check("setwin_busy",      {31'd0, busy},      32'd1);
      check("setwin_overflow",  {31'd0, overflow},  32'd0);
      cyc();
      check("setwin_resend_valid", {31'd0, aer_valid}, 32'd1);
      check("setwin_resend_addr",  {30'd0, aer_addr},  32'd2);
      cyc();
      check("setwin_done_busy", {31'd0, busy}, 32'd0);
      repeat (2) cyc();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
